instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/ifetch_queue.sv | 66 ++++++
 rtl/instruction_fetch.sv | 106 ++++++++++
 tb/tb_instruction_fetch.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// PC step, default reset address and fetch queue depth.
package ifetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      FULL = 2'd2
   } ifetch_state_e;

   localparam logic [1:0] ST_BOOT = 2'(BOOT);
   localparam logic [1:0] ST_RUN  = 2'(RUN);
   localparam logic [1:0] ST_FULL = 2'(FULL);

   localparam int unsigned PC_INC           = 4;
   localparam int unsigned DEFAULT_RESET_PC = 0;
   localparam int unsigned QUEUE_DEPTH      = 2;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: instruction memory read port, redirect input and the
// valid/ready instruction hand-off towards decode.
interface instruction_fetch_if #(
   parameter int unsigned DATA_BITS = 32
);
   logic [DATA_BITS-1:0] index;
   logic [DATA_BITS-1:0] instruction;
   logic                 redirect_valid;
   logic [DATA_BITS-1:0] redirect_pc;
   logic                 inst_valid;
   logic                 inst_ready;
   logic [DATA_BITS-1:0] inst_out;
   logic [DATA_BITS-1:0] inst_pc;

   modport master (
      output index, inst_valid, inst_out, inst_pc,
      input  instruction, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  index, inst_valid, inst_out, inst_pc,
      output instruction, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/ifetch_queue.sv
// Two-entry in-order instruction/PC queue; entry 0 is always the head, so
// the head outputs come straight from registers.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int unsigned DATA_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [DATA_BITS-1:0] push_inst,
   input  logic [DATA_BITS-1:0] push_pc,
   input  logic                 pop,
   input  logic                 flush,
   output logic [1:0]           occ,
   output logic [DATA_BITS-1:0] head_inst,
   output logic [DATA_BITS-1:0] head_pc
);

   logic [1:0][DATA_BITS-1:0] inst_q, inst_n;
   logic [1:0][DATA_BITS-1:0] pc_q, pc_n;
   logic [1:0]                occ_q, occ_n;
   logic                      pop_ok;
   logic                      push_ok;
   logic                      wr_sel;

   // Shift on pop, then append behind whatever remains.
   always_comb begin
      inst_n  = inst_q;
      pc_n    = pc_q;
      occ_n   = occ_q;
      pop_ok  = pop && (occ_q != 2'd0);
      push_ok = push && ((occ_q - 2'(pop_ok)) < 2'(QUEUE_DEPTH));
      wr_sel  = 1'(occ_q - 2'(pop_ok));
      if (flush) begin
         occ_n = 2'd0;
      end else begin
         if (pop_ok) begin
            inst_n[0] = inst_q[1];
            pc_n[0]   = pc_q[1];
         end
         if (push_ok) begin
            inst_n[wr_sel] = push_inst;
            pc_n[wr_sel]   = push_pc;
         end
         occ_n = occ_q - 2'(pop_ok) + 2'(push_ok);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q <= '0;
         pc_q   <= '0;
         occ_q  <= 2'd0;
      end else begin
         inst_q <= inst_n;
         pc_q   <= pc_n;
         occ_q  <= occ_n;
      end
   end

   assign occ       = occ_q;
   assign head_inst = inst_q[0];
   assign head_pc   = pc_q[0];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues word reads to a synchronous instruction memory and
// queues responses for decode. Define IFETCH_COUNT_EN to add the fetch_count output.
module instruction_fetch
   import ifetch_pkg::*;
#(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned IMEM_SIZE = 128,
   parameter int unsigned RESET_PC  = DEFAULT_RESET_PC
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instruction_fetch_if.master  bus
`ifdef IFETCH_COUNT_EN
   ,
   output logic [DATA_BITS-1:0] fetch_count
`endif
);

   localparam int unsigned IDX_BITS = $clog2(IMEM_SIZE);

   logic [DATA_BITS-1:0] pc_q, pc_n;
   logic [DATA_BITS-1:0] fl_pc_q, fl_pc_n;
   logic                 inflight_q, inflight_n;
   logic [1:0]           state_q, state_n;
   logic [1:0]           occ;
   logic [2:0]           load;
   logic                 pop;
   logic                 push;
   logic                 issue;

   assign bus.index      = DATA_BITS'(pc_q[IDX_BITS+1:2]);
   assign bus.inst_valid = (occ != 2'd0);
   assign pop            = bus.inst_valid & bus.inst_ready;
   assign push           = inflight_q & ~bus.redirect_valid;

   // Queued plus in-flight words after this cycle's pop must leave room for one more.
   assign load  = 3'(occ) - 3'(pop) + 3'(inflight_q);
   assign issue = ~bus.redirect_valid & (load < 3'd2);

   ifetch_queue #(
      .DATA_BITS (DATA_BITS)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_inst (bus.instruction),
      .push_pc   (fl_pc_q),
      .pop       (pop),
      .flush     (bus.redirect_valid),
      .occ       (occ),
      .head_inst (bus.inst_out),
      .head_pc   (bus.inst_pc)
   );

   always_comb begin
      pc_n       = pc_q;
      fl_pc_n    = fl_pc_q;
      inflight_n = 1'b0;
      state_n    = state_q;

      if (bus.redirect_valid) begin
         pc_n = bus.redirect_pc & ~DATA_BITS'(3);
      end else if (issue) begin
         pc_n       = pc_q + DATA_BITS'(PC_INC);
         fl_pc_n    = pc_q;
         inflight_n = 1'b1;
      end

      if (bus.redirect_valid) begin
         state_n = ST_RUN;
      end else begin
         case (state_q)
            ST_BOOT: state_n = ST_RUN;
            ST_RUN:  if (!pop && (occ == 2'd2 || (occ == 2'd1 && push))) state_n = ST_FULL;
            ST_FULL: if (pop) state_n = ST_RUN;
            default: state_n = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= DATA_BITS'(RESET_PC);
         fl_pc_q    <= '0;
         inflight_q <= 1'b0;
         state_q    <= ST_BOOT;
      end else begin
         pc_q       <= pc_n;
         fl_pc_q    <= fl_pc_n;
         inflight_q <= inflight_n;
         state_q    <= state_n;
      end
   end

`ifdef IFETCH_COUNT_EN
   // A pop in a redirect cycle was still delivered, so it is counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (pop) begin
         fetch_count <= fetch_count + DATA_BITS'(1);
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed redirect table, multi-cycle
// corner sequences, and a randomized run checked against a stream-level model.
module tb_instruction_fetch;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 128;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   instruction_fetch_if #(.DATA_BITS(DW)) bus ();

`ifdef IFETCH_COUNT_EN
   logic [DW-1:0] fetch_count;
   logic [DW-1:0] exp_count;
`endif

   instruction_fetch #(
      .DATA_BITS (DW),
      .IMEM_SIZE (DEPTH),
      .RESET_PC  (0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef IFETCH_COUNT_EN
      ,
      .fetch_count (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory holding word k = k + 100.
   always @(posedge clk)
      bus.instruction <= (bus.index < DW'(DEPTH)) ? bus.index + 32'd100 : 32'hdead_beef;

`ifdef IFETCH_COUNT_EN
   always @(posedge clk or negedge rst_n)
      if (!rst_n) exp_count <= '0;
      else if (bus.inst_valid && bus.inst_ready) exp_count <= exp_count + 32'd1;
`endif

   typedef struct {
      logic [DW-1:0] rpc;
      bit            fill;
      logic [DW-1:0] idx;
      logic [DW-1:0] pc0;
      logic [DW-1:0] w0;
      logic [DW-1:0] pc1;
      logic [DW-1:0] w1;
   } redir_vec_t;

   redir_vec_t    vt [5];
   int            since_restart;
   logic [DW-1:0] exp_pc;
   bit            rnd_ready;
   bit            rnd_redir;
   logic [DW-1:0] rnd_pc;

   function automatic logic [DW-1:0] word_at(input logic [DW-1:0] pc);
      return DW'(((pc >> 2) % DEPTH) + 100);
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Leaves the bench at the negedge where rst_n rises: cycle 0.
   task automatic do_reset();
      @(negedge clk);
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.inst_ready     = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      vt[0] = '{32'h40,        1'b1, 32'd16,  32'h40,        32'd116, 32'h44,   32'd117};
      vt[1] = '{32'h1FC,       1'b0, 32'd127, 32'h1FC,       32'd227, 32'h200,  32'd100};
      vt[2] = '{32'h43,        1'b1, 32'd16,  32'h40,        32'd116, 32'h44,   32'd117};
      vt[3] = '{32'hFFFF_FFFC, 1'b0, 32'd127, 32'hFFFF_FFFC, 32'd227, 32'h0,    32'd100};
      vt[4] = '{32'h1000,      1'b1, 32'd0,   32'h1000,      32'd100, 32'h1004, 32'd101};

      // Values held during reset
      repeat (2) tick();
      check("rst_valid", DW'(bus.inst_valid), 32'd0);
      check("rst_out",   bus.inst_out,        32'd0);
      check("rst_pc",    bus.inst_pc,         32'd0);
      check("rst_index", bus.index,           32'd0);
`ifdef IFETCH_COUNT_EN
      check("rst_count", fetch_count, 32'd0);
`endif

      // Startup latency
      do_reset();
      check("c0_index", bus.index, 32'd0);
      tick();
      check("c1_index", bus.index,           32'd1);
      check("c1_valid", DW'(bus.inst_valid), 32'd0);
      tick();
      check("c2_index", bus.index,           32'd2);
      check("c2_valid", DW'(bus.inst_valid), 32'd1);
      check("c2_out",   bus.inst_out,        32'd100);
      check("c2_pc",    bus.inst_pc,         32'd0);

      // Stall: head holds, fetch stops once two words are held
      bus.inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", DW'(bus.inst_valid), 32'd1);
         check("stall_out",   bus.inst_out,        32'd100);
         check("stall_pc",    bus.inst_pc,         32'd0);
         check("stall_index", bus.index,           32'd2);
      end
      bus.inst_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("drain_valid", DW'(bus.inst_valid), 32'd1);
         check("drain_out",   bus.inst_out,        DW'(100 + k));
         check("drain_pc",    bus.inst_pc,         DW'(4 * k));
         tick();
      end

      // Redirect table
      for (int t = 0; t < 5; t++) begin
         bus.inst_ready = !vt[t].fill;
         repeat (3) tick();
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = vt[t].rpc;
         bus.inst_ready     = 1'b1;
         tick();
         bus.redirect_valid = 1'b0;
         check("redir_r1_valid", DW'(bus.inst_valid), 32'd0);
         check("redir_r1_index", bus.index,           vt[t].idx);
         tick();
         check("redir_r2_valid", DW'(bus.inst_valid), 32'd0);
         tick();
         check("redir_r3_valid", DW'(bus.inst_valid), 32'd1);
         check("redir_r3_pc",    bus.inst_pc,         vt[t].pc0);
         check("redir_r3_out",   bus.inst_out,        vt[t].w0);
         tick();
         check("redir_r4_pc",    bus.inst_pc,         vt[t].pc1);
         check("redir_r4_out",   bus.inst_out,        vt[t].w1);
      end

      // Back-to-back redirects: the second target wins
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h80;
      tick();
      bus.redirect_pc    = 32'h100;
      tick();
      bus.redirect_valid = 1'b0;
      check("b2b_index", bus.index,           32'd64);
      check("b2b_valid", DW'(bus.inst_valid), 32'd0);
      tick();
      check("b2b_valid2", DW'(bus.inst_valid), 32'd0);
      tick();
      check("b2b_valid3", DW'(bus.inst_valid), 32'd1);
      check("b2b_pc",     bus.inst_pc,         32'h100);
      check("b2b_out",    bus.inst_out,        32'd164);

      // Asynchronous reset with a full queue
      bus.inst_ready = 1'b0;
      repeat (3) tick();
      check("prerst_valid", DW'(bus.inst_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", DW'(bus.inst_valid), 32'd0);
      check("arst_out",   bus.inst_out,        32'd0);
      check("arst_index", bus.index,           32'd0);
      @(negedge clk);
      rst_n          = 1'b1;
      bus.inst_ready = 1'b1;
      check("rerst_c0_index", bus.index, 32'd0);
      repeat (2) tick();
      check("rerst_valid", DW'(bus.inst_valid), 32'd1);
      check("rerst_out",   bus.inst_out,        32'd100);
      check("rerst_pc",    bus.inst_pc,         32'd0);

      // Ten pops, then one pop coinciding with a redirect
      repeat (10) tick();
      check("pre_cnt_out", bus.inst_out, 32'd110);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      tick();
      bus.redirect_valid = 1'b0;
`ifdef IFETCH_COUNT_EN
      check("count_11", fetch_count, 32'd11);
`endif

      // Randomized run against the stream model
      do_reset();
      since_restart = 0;
      exp_pc        = '0;
      for (int i = 0; i < 3000; i++) begin
         check("rnd_valid", DW'(bus.inst_valid), DW'(since_restart >= 2));
         if (since_restart >= 2) begin
            check("rnd_pc",  bus.inst_pc,  exp_pc);
            check("rnd_out", bus.inst_out, word_at(exp_pc));
         end
         rnd_ready = ($urandom_range(0, 9) < 7);
         rnd_redir = ($urandom_range(0, 19) == 0);
         rnd_pc    = $urandom();
         bus.inst_ready     = rnd_ready;
         bus.redirect_valid = rnd_redir;
         bus.redirect_pc    = rnd_pc;
         if (since_restart >= 2 && rnd_ready) exp_pc = exp_pc + 32'd4;
         if (rnd_redir) begin
            exp_pc        = rnd_pc & ~32'd3;
            since_restart = 0;
         end else if (since_restart < 2) begin
            since_restart++;
         end
         tick();
      end
      bus.redirect_valid = 1'b0;

`ifdef IFETCH_COUNT_EN
      check("count_total", fetch_count, exp_count);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
